studio_video_out: RTL

// - Pixel output stage between the CDP1861-style video generator and the emu VGA_* outputs.
// - Generates the pixel clock enable and registers pixel/blank/sync through a fixed 2-stage pipeline.
// - Scales PIX_W-bit intensity to OUT_W-bit RGB and applies a 2-bit tint (white/red/green/blue).
// - Tint changes are frame-synchronous. Keeps a frame counter and line parity.

---
 rtl/studio_video_pkg.sv | 27 ++
 rtl/studio_ce_div.sv | 31 +++
 rtl/studio_video_out.sv | 129 ++++++++++++
 3 files changed

// File: rtl/studio_video_pkg.sv
// Shared types and helpers for the studio video output stage.
package studio_video_pkg;

   typedef enum logic [1:0] {
      TINT_WHITE = 2'd0,
      TINT_RED   = 2'd1,
      TINT_GREEN = 2'd2,
      TINT_BLUE  = 2'd3
   } tint_e;

   localparam int LVL_MAX_W = 16;

   // Replicate pix MSB-first across out_w bits; bits at and above out_w stay 0.
   function automatic logic [LVL_MAX_W-1:0] expand_lvl(input logic [LVL_MAX_W-1:0] pix,
                                                       input int pix_w,
                                                       input int out_w);
      logic [LVL_MAX_W-1:0] lvl;
      lvl = '0;
      for (int i = 0; i < LVL_MAX_W; i++) begin
         if (i < out_w) begin
            lvl[4'(out_w - 1 - i)] = pix[4'(pix_w - 1 - (i % pix_w))];
         end
      end
      return lvl;
   endfunction

endpackage

// File: rtl/studio_ce_div.sv
// Pixel clock-enable divider: free-running counter with a registered terminal-count pulse.
module studio_ce_div #(
   parameter int CE_DIV = 1
) (
   input  logic clk_sys,
   input  logic reset_n,
   output logic ce_pix
);

   localparam logic [3:0] CNT_LAST = 4'(CE_DIV - 1);

   logic [3:0] cnt_q, cnt_d;
   logic       ce_q;

   always_comb begin
      cnt_d = (cnt_q == CNT_LAST) ? 4'd0 : cnt_q + 4'd1;
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= 4'd0;
         ce_q  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         ce_q  <= (cnt_q == CNT_LAST);
      end
   end

   assign ce_pix = ce_q;

endmodule

// File: rtl/studio_video_out.sv
// Pixel output stage: 2-stage ce_pix pipeline, intensity scaling, frame-synchronous tint.
// Optional scanline dimming on odd lines is built only with STUDIO_VIDEO_SCANLINES_EN.
module studio_video_out
   import studio_video_pkg::*;
#(
   parameter int PIX_W  = 1,
   parameter int OUT_W  = 8,
   parameter int CE_DIV = 1,
   parameter int FCNT_W = 16
) (
   input  logic              clk_sys,
   input  logic              reset_n,
   input  logic [PIX_W-1:0]  pix_in,
   input  logic              hblank_in,
   input  logic              vblank_in,
   input  logic              hsync_in,
   input  logic              vsync_in,
   input  logic [1:0]        tint,
   input  logic              scan_en,
   output logic              ce_pix,
   output logic [OUT_W-1:0]  vga_r,
   output logic [OUT_W-1:0]  vga_g,
   output logic [OUT_W-1:0]  vga_b,
   output logic              vga_hs,
   output logic              vga_vs,
   output logic              vga_de,
   output logic [FCNT_W-1:0] frame_cnt,
   output logic              line_odd
);

   studio_ce_div #(.CE_DIV(CE_DIV)) u_ce_div (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .ce_pix  (ce_pix)
   );

   logic [PIX_W-1:0]  pix1_q;
   logic              hb1_q, vb1_q, hs1_q, vs1_q;
   logic [OUT_W-1:0]  r_q, g_q, b_q, r_d, g_d, b_d;
   logic              de_q, hs2_q, vs2_q, hb2_q;
   logic [FCNT_W-1:0] frame_q, frame_d;
   logic              odd_q, odd_d;
   tint_e             tint_q, tint_d;

   logic              vs_rise, hb_fall, blank;
   logic              en_r, en_g, en_b;
   logic [OUT_W-1:0]  lvl;

`ifndef STUDIO_VIDEO_SCANLINES_EN
   logic unused_scan_en;
   assign unused_scan_en = scan_en;
`endif

   // S2 holds the previous S1 sync/blank, so edges are detected against it.
   always_comb begin
      vs_rise = vs1_q & ~vs2_q;
      hb_fall = ~hb1_q & hb2_q;
      tint_d  = tint_q;
      frame_d = frame_q;
      odd_d   = odd_q;
      if (vs_rise) begin
         tint_d  = tint_e'(tint);
         frame_d = frame_q + FCNT_W'(1);
         odd_d   = 1'b0;
      end else if (hb_fall) begin
         odd_d   = ~odd_q;
      end

      blank = hb1_q | vb1_q;
      lvl   = OUT_W'(expand_lvl(LVL_MAX_W'(pix1_q), PIX_W, OUT_W));
`ifdef STUDIO_VIDEO_SCANLINES_EN
      if (scan_en && odd_d) begin
         lvl = lvl >> 1;
      end
`endif
      en_r = (tint_d == TINT_WHITE) || (tint_d == TINT_RED);
      en_g = (tint_d == TINT_WHITE) || (tint_d == TINT_GREEN);
      en_b = (tint_d == TINT_WHITE) || (tint_d == TINT_BLUE);
      r_d  = (!blank && en_r) ? lvl : '0;
      g_d  = (!blank && en_g) ? lvl : '0;
      b_d  = (!blank && en_b) ? lvl : '0;
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         pix1_q  <= '0;
         hb1_q   <= 1'b0;
         vb1_q   <= 1'b0;
         hs1_q   <= 1'b0;
         vs1_q   <= 1'b0;
         r_q     <= '0;
         g_q     <= '0;
         b_q     <= '0;
         de_q    <= 1'b0;
         hs2_q   <= 1'b0;
         vs2_q   <= 1'b0;
         hb2_q   <= 1'b0;
         frame_q <= '0;
         odd_q   <= 1'b0;
         tint_q  <= TINT_WHITE;
      end else if (ce_pix) begin
         pix1_q  <= pix_in;
         hb1_q   <= hblank_in;
         vb1_q   <= vblank_in;
         hs1_q   <= hsync_in;
         vs1_q   <= vsync_in;
         r_q     <= r_d;
         g_q     <= g_d;
         b_q     <= b_d;
         de_q    <= ~blank;
         hs2_q   <= hs1_q;
         vs2_q   <= vs1_q;
         hb2_q   <= hb1_q;
         frame_q <= frame_d;
         odd_q   <= odd_d;
         tint_q  <= tint_d;
      end
   end

   assign vga_r     = r_q;
   assign vga_g     = g_q;
   assign vga_b     = b_q;
   assign vga_hs    = hs2_q;
   assign vga_vs    = vs2_q;
   assign vga_de    = de_q;
   assign frame_cnt = frame_q;
   assign line_odd  = odd_q;

endmodule
